// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants for the interrupt block: register field widths,
// vector defaults and sequencer state encodings.
package interrupt_sequencer_pkg;

    localparam int INT_PRI_W = 3;
    localparam int INT_LVL_W = 3;
    localparam logic [15:0] INT_VEC_BASE = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_VECT = 2'd2
    } state_t;

    function automatic logic [15:0] int_vec_addr(
        input logic [15:0] base,
        input logic [INT_PRI_W-1:0] pri,
        input int sh
    );
        return base + (16'(pri) << sh);
    endfunction

endpackage

// File: rtl/int_level_stack.sv
// Synchronous LIFO of saved in-service levels.
// A same-cycle push and pop overwrites the top entry.
module int_level_stack
    import interrupt_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [INT_LVL_W-1:0] din,
    output logic [INT_LVL_W-1:0] top,
    output logic [2:0]           count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INT_LVL_W-1:0] mem [DEPTH];
    logic [AW-1:0]        top_idx;
    logic [AW-1:0]        wr_idx;

    assign top_idx = AW'(count - 3'd1);
    assign wr_idx  = AW'(count);
    assign top     = (count == 3'd0) ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && pop && count != 3'd0) begin
            mem[top_idx] <= din;
        end else if (push && count < 3'(DEPTH)) begin
            mem[wr_idx] <= din;
            count       <= count + 3'd1;
        end else if (pop && count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer with priority nesting.
// Nesting stack is built only when INT_NESTING_EN is defined.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] VEC_BASE        = INT_VEC_BASE,
    parameter int          VEC_STRIDE_LOG2 = 2,
    parameter int          STACK_DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 INT1,
    input  logic [INT_PRI_W-1:0] PRI,
    input  logic                 IEN,
    input  logic                 INTACK,
    input  logic                 RETI,
    output logic                 INT_REQ,
    output logic                 VEC_VALID,
    output logic [15:0]          VECTOR,
    output logic [INT_LVL_W-1:0] LEVEL,
    output logic [2:0]           DEPTH,
    output logic                 OVERFLOW
);

`ifdef INT_NESTING_EN
    localparam int EFF_DEPTH = STACK_DEPTH;
`else
    localparam int EFF_DEPTH = (STACK_DEPTH < 1) ? STACK_DEPTH : 1;
`endif

    state_t state, nxt;

    logic full, higher, eligible;
    logic push, pop;
    logic [INT_LVL_W-1:0] pop_level;

    assign full   = DEPTH >= 3'(EFF_DEPTH);
    assign higher = PRI > LEVEL;
    assign push   = (state == ST_PEND) && INTACK;
    assign pop    = RETI && (DEPTH != 3'd0);

`ifdef INT_NESTING_EN
    assign eligible = INT1 && IEN && higher && !full;

    logic [INT_LVL_W-1:0] stk_top;
    logic [INT_LVL_W-1:0] push_data;

    // a simultaneous pop hands the popped level straight back to the push
    assign push_data = pop ? stk_top : LEVEL;
    assign pop_level = stk_top;

    int_level_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .top   (stk_top),
        .count (DEPTH)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            OVERFLOW <= 1'b0;
        end else if (INT1 && full && higher) begin
            OVERFLOW <= 1'b1;
        end
    end
`else
    assign eligible  = INT1 && IEN && higher && !full && (LEVEL == '0);
    assign pop_level = '0;
    assign OVERFLOW  = 1'b0;

    logic in_svc;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            in_svc <= 1'b0;
        end else if (push) begin
            in_svc <= 1'b1;
        end else if (pop) begin
            in_svc <= 1'b0;
        end
    end

    assign DEPTH = {2'b00, in_svc};
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: if (eligible) nxt = ST_PEND;
            ST_PEND: begin
                if (INTACK) nxt = ST_VECT;
                else if (!eligible) nxt = ST_IDLE;
            end
            ST_VECT: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            INT_REQ   <= 1'b0;
            VEC_VALID <= 1'b0;
            VECTOR    <= 16'h0000;
            LEVEL     <= '0;
        end else begin
            state     <= nxt;
            INT_REQ   <= (nxt == ST_PEND);
            VEC_VALID <= push;
            if (push) begin
                VECTOR <= int_vec_addr(VEC_BASE, PRI, VEC_STRIDE_LOG2);
                LEVEL  <= PRI;
            end else if (pop) begin
                LEVEL <= pop_level;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer.
// Expectations follow the INT_NESTING_EN setting of the build.
module tb_interrupt_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        INT1;
    logic [2:0]  PRI;
    logic        IEN;
    logic        INTACK;
    logic        RETI;
    logic        INT_REQ;
    logic        VEC_VALID;
    logic [15:0] VECTOR;
    logic [2:0]  LEVEL;
    logic [2:0]  DEPTH;
    logic        OVERFLOW;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    interrupt_sequencer #(
        .VEC_BASE        (16'h0010),
        .VEC_STRIDE_LOG2 (2),
        .STACK_DEPTH     (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .INT1      (INT1),
        .PRI       (PRI),
        .IEN       (IEN),
        .INTACK    (INTACK),
        .RETI      (RETI),
        .INT_REQ   (INT_REQ),
        .VEC_VALID (VEC_VALID),
        .VECTOR    (VECTOR),
        .LEVEL     (LEVEL),
        .DEPTH     (DEPTH),
        .OVERFLOW  (OVERFLOW)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   16'(INT_REQ),   16'h0);
        chk({tag, "_vv"},    16'(VEC_VALID), 16'h0);
        chk({tag, "_vec"},   VECTOR,         16'h0000);
        chk({tag, "_lvl"},   16'(LEVEL),     16'h0);
        chk({tag, "_depth"}, 16'(DEPTH),     16'h0);
        chk({tag, "_ovf"},   16'(OVERFLOW),  16'h0);
    endtask

    initial begin
        RESET  = 1'b0;
        INT1   = 1'b0;
        PRI    = 3'd0;
        IEN    = 1'b0;
        INTACK = 1'b0;
        RETI   = 1'b0;
        step();
        step();
        chk_reset("rst");

        RESET = 1'b1;
        INT1  = 1'b1;
        PRI   = 3'd3;
        IEN   = 1'b1;
        step();
        chk("req_p3", 16'(INT_REQ), 16'h1);
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        chk("vv_p3",    16'(VEC_VALID), 16'h1);
        chk("vec_p3",   VECTOR,         16'h001C);
        chk("lvl_p3",   16'(LEVEL),     16'h3);
        chk("depth_p3", 16'(DEPTH),     16'h1);
        chk("req_ack",  16'(INT_REQ),   16'h0);
        step();
        chk("vv_pulse", 16'(VEC_VALID), 16'h0);
        chk("vec_hold", VECTOR,         16'h001C);

        PRI = 3'd2;
        step();
        chk("req_lower", 16'(INT_REQ), 16'h0);
        step();
        chk("req_lower2", 16'(INT_REQ), 16'h0);

        PRI = 3'd5;
        step();
`ifdef INT_NESTING_EN
        chk("req_p5", 16'(INT_REQ), 16'h1);
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        chk("vec_p5",   VECTOR,     16'h0024);
        chk("lvl_p5",   16'(LEVEL), 16'h5);
        chk("depth_p5", 16'(DEPTH), 16'h2);
        INT1 = 1'b0;
        RETI = 1'b1;
        step();
        chk("reti1_lvl",   16'(LEVEL), 16'h3);
        chk("reti1_depth", 16'(DEPTH), 16'h1);
        step();
        RETI = 1'b0;
        chk("reti2_lvl",   16'(LEVEL), 16'h0);
        chk("reti2_depth", 16'(DEPTH), 16'h0);
`else
        chk("req_nopre", 16'(INT_REQ), 16'h0);
        INT1 = 1'b0;
        RETI = 1'b1;
        step();
        RETI = 1'b0;
        chk("reti_lvl",   16'(LEVEL), 16'h0);
        chk("reti_depth", 16'(DEPTH), 16'h0);
`endif

        RETI = 1'b1;
        step();
        RETI = 1'b0;
        chk("reti0_lvl",   16'(LEVEL),     16'h0);
        chk("reti0_depth", 16'(DEPTH),     16'h0);
        chk("reti0_vv",    16'(VEC_VALID), 16'h0);

        INT1 = 1'b1;
        PRI  = 3'd2;
        step();
        chk("wd_req", 16'(INT_REQ), 16'h1);
        INT1 = 1'b0;
        step();
        chk("wd_drop", 16'(INT_REQ),   16'h0);
        chk("wd_vv",   16'(VEC_VALID), 16'h0);
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        chk("ign_vv",    16'(VEC_VALID), 16'h0);
        chk("ign_depth", 16'(DEPTH),     16'h0);
        chk("ign_lvl",   16'(LEVEL),     16'h0);

`ifdef INT_NESTING_EN
        INT1 = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            PRI = 3'(p);
            step();
            chk("nest_req", 16'(INT_REQ), 16'h1);
            INTACK = 1'b1;
            step();
            INTACK = 1'b0;
            chk("nest_lvl",   16'(LEVEL), 16'(p));
            chk("nest_depth", 16'(DEPTH), 16'(p));
            step();
        end
        PRI = 3'd7;
        step();
        chk("full_req", 16'(INT_REQ),  16'h0);
        chk("full_ovf", 16'(OVERFLOW), 16'h1);
        RETI = 1'b1;
        step();
        RETI = 1'b0;
        chk("full_pop_lvl", 16'(LEVEL),   16'h3);
        chk("full_pop_req", 16'(INT_REQ), 16'h0);
        step();
        chk("full_rise", 16'(INT_REQ), 16'h1);

        PRI  = 3'd6;
        RETI = 1'b1;
        step();
        chk("pre_lvl",   16'(LEVEL),   16'h2);
        chk("pre_depth", 16'(DEPTH),   16'h2);
        chk("pre_req",   16'(INT_REQ), 16'h1);
        INTACK = 1'b1;
        step();
        RETI   = 1'b0;
        INTACK = 1'b0;
        chk("both_lvl",   16'(LEVEL),     16'h6);
        chk("both_depth", 16'(DEPTH),     16'h2);
        chk("both_vec",   VECTOR,         16'h0028);
        chk("both_vv",    16'(VEC_VALID), 16'h1);
`else
        INT1 = 1'b1;
        PRI  = 3'd1;
        step();
        chk("p1_req", 16'(INT_REQ), 16'h1);
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        chk("p1_vec",   VECTOR,     16'h0014);
        chk("p1_lvl",   16'(LEVEL), 16'h1);
        chk("p1_depth", 16'(DEPTH), 16'h1);
        PRI = 3'd7;
        step();
        step();
        chk("p7_req", 16'(INT_REQ),  16'h0);
        chk("p7_ovf", 16'(OVERFLOW), 16'h0);
        RETI = 1'b1;
        step();
        RETI = 1'b0;
        chk("p7_reti_lvl", 16'(LEVEL),   16'h0);
        chk("p7_reti_req", 16'(INT_REQ), 16'h0);
        step();
        chk("p7_rise", 16'(INT_REQ), 16'h1);
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        chk("p7_vec", VECTOR,     16'h002C);
        chk("p7_lvl", 16'(LEVEL), 16'h7);
        chk("p7_vv",  16'(VEC_VALID), 16'h1);
`endif

        RESET = 1'b0;
        step();
        chk_reset("rst_vect");
        RESET = 1'b1;
        INT1  = 1'b0;
        step();
        chk("post_rst_req", 16'(INT_REQ), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequences interrupt entry and exit for the CPU core. Consumes the summary request and 3-bit priority produced by the interrupt mask register, raises a request to the core, and on acknowledge issues a vector address. It tracks the in-service priority level on a small nesting stack so only strictly higher priorities preempt, and it restores the previous level on return-from-interrupt.

## Interface
Parameters:
- VEC_BASE, 16'h0010 — vector address for priority 0 (priority 0 is never issued).
- VEC_STRIDE_LOG2, 2 — log2 of the byte spacing between vectors.
- STACK_DEPTH, 4 — maximum number of nested in-service levels (2..7).

Ports:
- CLK  in  1  — single system clock, rising edge.
- RESET  in  1  — synchronous, active-low reset.
- INT1  in  1  — summary interrupt request from the mask register.
- PRI  in  3  — highest active priority from the mask register; 0 = none.
- IEN  in  1  — global interrupt enable from the core.
- INTACK  in  1  — one-cycle acknowledge pulse from the core at an instruction boundary.
- RETI  in  1  — one-cycle return-from-interrupt pulse from the core.
- INT_REQ  out  1  — interrupt request to the core.
- VEC_VALID  out  1  — one-cycle strobe qualifying VECTOR.
- VECTOR  out  16  — vector address; valid only while VEC_VALID is high.
- LEVEL  out  3  — current in-service priority; 0 = none.
- DEPTH  out  3  — number of entries on the nesting stack.
- OVERFLOW  out  1  — sticky flag; cleared only by reset.

## Operation
- Eligible when INT1 & IEN & (PRI > LEVEL) & (DEPTH < STACK_DEPTH).
- States are IDLE, PEND and VECT.
- IDLE → PEND when eligible.
- PEND → VECT when INTACK.
- PEND → IDLE when no longer eligible and INTACK is low. The request is withdrawn and no vector is issued.
- VECT → IDLE unconditionally after one cycle.
- Entry on the PEND + INTACK edge:
  - PRI is sampled.
  - LEVEL is pushed onto the stack and DEPTH increments.
  - LEVEL takes the sampled PRI.
  - VECTOR is set to VEC_BASE + (PRI << VEC_STRIDE_LOG2), truncated to 16 bits.
- RETI, in any state:
  - If DEPTH > 0, pop into LEVEL and decrement DEPTH.
  - If DEPTH = 0, RETI is ignored and LEVEL stays 0.
- RETI and INTACK in the same cycle in PEND: the pop happens first, then the push uses the popped level. Net DEPTH is unchanged and LEVEL = PRI.
- An INTACK seen in IDLE or VECT is ignored.
- INT1 while DEPTH = STACK_DEPTH and PRI > LEVEL sets OVERFLOW. The request is held off until a RETI.
- The PRI comparison is unsigned 3-bit.

## Timing
- Reset values: INT_REQ=0, VEC_VALID=0, VECTOR=16'h0000, LEVEL=0, DEPTH=0, OVERFLOW=0, state IDLE, stack cleared.
- INT_REQ is registered. It rises one cycle after eligibility is first seen and is high exactly while in PEND.
- Latency: INTACK at edge N gives VEC_VALID=1 and the updated LEVEL/DEPTH after edge N. INT_REQ is low after edge N.
- VEC_VALID lasts exactly one cycle. VECTOR holds its last value afterwards.
- The earliest new INT_REQ after a vector is two cycles after VEC_VALID (VECT → IDLE → PEND).
- RESET low in any state returns everything to its reset value on that edge. This includes aborting a pending or in-flight vector.

## Configuration
- INT_NESTING_EN defined:
  - Full nesting as above, with STACK_DEPTH entries.
- INT_NESTING_EN undefined:
  - Effective depth is 1 and no stack storage is built.
  - Eligibility additionally requires LEVEL = 0, so nothing preempts an interrupt in service.
  - RETI restores LEVEL to 0.
  - OVERFLOW is tied to 0.

## Structure
- State encodings and the VEC_BASE default go in the shared constants include, alongside the existing INT_* register constants.
- One sub-module, int_level_stack, is a synchronous LIFO of 3-bit levels.
  - Inputs: push/pop with data in.
  - Outputs: top of stack and depth.
  - Same-cycle push+pop replaces the top entry.

## Test plan
- After reset, INT1=1, PRI=3, IEN=1 → INT_REQ=1 one cycle later. INTACK pulse → VEC_VALID=1, VECTOR=16'h001C, LEVEL=3, DEPTH=1.
- While LEVEL=3, present PRI=2 → INT_REQ stays 0. Then PRI=5 → preempt, VECTOR=16'h0024, LEVEL=5, DEPTH=2. RETI → LEVEL=3, DEPTH=1. RETI → LEVEL=0, DEPTH=0.
- In PEND, drop INT1 before INTACK → INT_REQ=0 next cycle, no VEC_VALID. A later INTACK is ignored.
- Nest PRI 1,2,3,4 → DEPTH=4. Present PRI=7 → INT_REQ=0, OVERFLOW=1. RETI → INT_REQ rises.
- RETI with DEPTH=0 → LEVEL=0, DEPTH=0, no change. RETI and INTACK together in PEND at LEVEL=2, PRI=6 → LEVEL=6, DEPTH unchanged.
- Pull RESET low in VECT → next cycle all outputs are at reset values. Without INT_NESTING_EN, PRI=7 while LEVEL=1 → no INT_REQ.
